// File: rtl/seg7_digit_reader.sv
// Reads an active-low 7-segment bus, debounces it and decodes stable patterns
// back to decimal digits, keeping a short history and an acceptance count.
module seg7_digit_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        CLOCK_50,
  input  logic        RST,
  input  logic [6:0]  SEG,
  output logic [3:0]  DIGIT,
  output logic        VALID,
  output logic        ERR,
  output logic [15:0] HIST,
  output logic [7:0]  COUNT
);

  typedef enum logic {
    SETTLE = 1'b0,
    DONE   = 1'b1
  } state_t;

  localparam logic [6:0] blank_c    = 7'h7F;
  localparam logic [7:0] cnt_last_c = 8'(STABLE_CYCLES - 1);

  // Returns {legal, digit}; anything not in the table (blank included) is not legal.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h40:   decode = {1'b1, 4'd0};
      7'h79:   decode = {1'b1, 4'd1};
      7'h24:   decode = {1'b1, 4'd2};
      7'h30:   decode = {1'b1, 4'd3};
      7'h19:   decode = {1'b1, 4'd4};
      7'h12:   decode = {1'b1, 4'd5};
      7'h02:   decode = {1'b1, 4'd6};
      7'h78:   decode = {1'b1, 4'd7};
      7'h00:   decode = {1'b1, 4'd8};
      7'h10:   decode = {1'b1, 4'd9};
      default: decode = {1'b0, 4'd0};
    endcase
  endfunction

  logic [6:0]  s1_r, s2_r, pat_r, last_r;
  logic [7:0]  cnt_r, count_r;
  state_t      state_r;
  logic [3:0]  digit_r;
  logic        valid_r, err_r;
  logic [15:0] hist_r;

  logic [6:0]  pat_s, last_s;
  logic [7:0]  cnt_s, count_s;
  state_t      state_s;
  logic [3:0]  digit_s;
  logic        valid_s, err_s;
  logic [15:0] hist_s;
  logic [4:0]  dec_s;

  // Two-flop synchronizer for the asynchronous segment bus.
  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      s1_r <= blank_c;
      s2_r <= blank_c;
    end else begin
      s1_r <= SEG;
      s2_r <= s1_r;
    end
  end

  // Debounce FSM next state plus evaluation of a pattern once it has settled.
  always_comb begin
    pat_s   = pat_r;
    cnt_s   = cnt_r;
    last_s  = last_r;
    state_s = state_r;
    digit_s = digit_r;
    hist_s  = hist_r;
    count_s = count_r;
    valid_s = 1'b0;
    err_s   = 1'b0;
    dec_s   = decode(pat_r);

    if (s2_r != pat_r) begin
      // Any change, even on the evaluation edge, restarts the settle window.
      pat_s   = s2_r;
      cnt_s   = 8'd0;
      state_s = SETTLE;
    end else begin
      case (state_r)
        SETTLE: begin
          if (cnt_r != cnt_last_c) begin
            cnt_s = 8'(cnt_r + 8'd1);
          end else begin
            state_s = DONE;
            if (pat_r == last_r) begin
              last_s = last_r;
            end else if (pat_r == blank_c) begin
              last_s = blank_c;
            end else if (dec_s[4]) begin
              digit_s = dec_s[3:0];
              valid_s = 1'b1;
              hist_s  = {hist_r[11:0], dec_s[3:0]};
              last_s  = pat_r;
              if (count_r != 8'd255) begin
                count_s = 8'(count_r + 8'd1);
              end else begin
                count_s = count_r;
              end
            end else begin
              err_s  = 1'b1;
              last_s = pat_r;
            end
          end
        end
        DONE:    state_s = DONE;
        default: state_s = DONE;
      endcase
    end
  end

  // Debounce state and registered outputs.
  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      pat_r   <= blank_c;
      last_r  <= blank_c;
      cnt_r   <= 8'd0;
      state_r <= DONE;
      digit_r <= 4'd0;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
      hist_r  <= 16'd0;
      count_r <= 8'd0;
    end else begin
      pat_r   <= pat_s;
      last_r  <= last_s;
      cnt_r   <= cnt_s;
      state_r <= state_s;
      digit_r <= digit_s;
      valid_r <= valid_s;
      err_r   <= err_s;
      hist_r  <= hist_s;
      count_r <= count_s;
    end
  end

  assign DIGIT = digit_r;
  assign VALID = valid_r;
  assign ERR   = err_r;
  assign HIST  = hist_r;
  assign COUNT = count_r;

endmodule
